// File: rtl/imem_responder_pkg.sv
// Shared types and constants for the instruction-memory responder.
// Fault classification lives here so the top stays focused on sequencing.
package imem_responder_pkg;

  localparam logic [31:0] NopInst = 32'h0000_0013;

  typedef enum logic [1:0] {
    FaultOk       = 2'b00,
    FaultMisalign = 2'b01,
    FaultRange    = 2'b10
  } imem_fault_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StWait = 2'b01,
    StResp = 2'b10
  } imem_state_e;

  // Misalignment takes precedence; span is the array size in bytes.
  function automatic imem_fault_e imem_fault(input logic [31:0] pc,
                                             input logic [31:0] base,
                                             input logic [32:0] span);
    logic [31:0] off;
    off = pc - base;
    if (pc[1:0] != 2'b00) return FaultMisalign;
    if ((pc < base) || ({1'b0, off} >= span)) return FaultRange;
    return FaultOk;
  endfunction

endpackage

// File: rtl/imem_array.sv
// DEPTH x 32 program store: one registered read port, one write port.
// A read and write to the same word on one edge returns the old word.
module imem_array #(
  parameter  int unsigned DEPTH = 4096,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rd_en_i,
  input  logic [AW-1:0] rd_addr_i,
  output logic [31:0]   rd_data_o,
  input  logic          wr_en_i,
  input  logic [AW-1:0] wr_addr_i,
  input  logic [31:0]   wr_data_i
);

  logic [31:0] mem_q [DEPTH];
  logic [31:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder for the fetch stage: captures a pc, waits
// WAIT_CYCLES, then presents the word with its pc and a fault code.
module imem_responder
  import imem_responder_pkg::*;
#(
  parameter  int unsigned DEPTH       = 4096,
  parameter  logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter  int unsigned WAIT_CYCLES = 0,
  localparam int unsigned AW          = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          n_rst_i,
  input  logic [31:0]   pc_i,
  input  logic          ce_i,
  input  logic          flush_i,
  input  logic          hold_i,
  output logic [31:0]   inst_o,
  output logic [31:0]   inst_pc_o,
  output logic          inst_valid_o,
  output logic [1:0]    fault_o,
  output logic          stall_req_o,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i
);

  localparam logic [3:0]  WaitInit = 4'(WAIT_CYCLES);
  localparam logic [32:0] Span     = 33'(DEPTH) * 33'd4;

  imem_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_pc_q;
  imem_fault_e fault_q;
  logic        nop_q;

  logic          accept;
  logic          load;
  logic [31:0]   fetch_pc;
  logic [AW-1:0] fetch_idx;
  imem_fault_e   fetch_fault;
  logic [31:0]   rd_data;

  // With no wait states the read happens on the capture edge, so pc_i feeds the array directly.
  assign fetch_pc    = (state_q == StWait) ? pc_q : pc_i;
  assign fetch_idx   = AW'((fetch_pc - BASE_ADDR) >> 2);
  assign fetch_fault = imem_fault(fetch_pc, BASE_ADDR, Span);
  assign accept      = ce_i && !flush_i &&
                       ((state_q == StIdle) || ((state_q == StResp) && !hold_i));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    load    = 1'b0;
    case (state_q)
      StWait: begin
        if (flush_i) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd1) begin
          state_d = StResp;
          load    = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StIdle, StResp: begin
        if ((state_q == StResp) && hold_i && !flush_i) begin
          state_d = StResp;
        end else if (accept) begin
          pc_d = pc_i;
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            load    = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitInit;
          end
        end else begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q   <= StIdle;
      cnt_q     <= 4'd0;
      pc_q      <= 32'd0;
      inst_pc_q <= 32'd0;
      fault_q   <= FaultOk;
      nop_q     <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      if (load) begin
        inst_pc_q <= fetch_pc;
        fault_q   <= fetch_fault;
        nop_q     <= (fetch_fault != FaultOk);
      end
    end
  end

  imem_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk_i     (clk_i),
    .rd_en_i   (load),
    .rd_addr_i (fetch_idx),
    .rd_data_o (rd_data),
    .wr_en_i   (load_we_i),
    .wr_addr_i (load_addr_i),
    .wr_data_i (load_data_i)
  );

  assign inst_o       = nop_q ? NopInst : rd_data;
  assign inst_pc_o    = inst_pc_q;
  assign inst_valid_o = (state_q == StResp);
  assign fault_o      = fault_q;
  assign stall_req_o  = !flush_i &&
                        ((state_q == StWait) ||
                         (accept && (WAIT_CYCLES != 0)) ||
                         ((state_q == StResp) && hold_i && ce_i));

endmodule

// File: tb/tb_imem_responder.sv
// Bench: two responders (0 and 3 wait states) share one stimulus stream; each
// has a transaction-level model checked every cycle, plus literal spot checks.
module tb_imem_responder;

  localparam int unsigned Depth = 64;
  localparam int unsigned AddrW = 6;
  localparam logic [31:0] Nop   = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n = 1'b0;
  logic             ce    = 1'b0;
  logic             flush = 1'b0;
  logic             hold  = 1'b0;
  logic             we    = 1'b0;
  logic [31:0]      pc    = 32'd0;
  logic [31:0]      wdata = 32'd0;
  logic [AddrW-1:0] waddr = '0;

  logic [31:0] inst_w  [2];
  logic [31:0] ipc_w   [2];
  logic        valid_w [2];
  logic        stall_w [2];
  logic [1:0]  fault_w [2];

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %h, want %h", name, $time, act, exp);
    end
  endtask

  function automatic logic [1:0] exp_fault(input logic [31:0] a);
    logic [31:0] off;
    off = a;  // base address is 0 in this bench
    if (a[1:0] != 2'b00) return 2'b01;
    if (64'(off) >= 64'(Depth) * 64'd4) return 2'b10;
    return 2'b00;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int unsigned W = (g == 0) ? 0 : 3;

    imem_responder #(
      .DEPTH       (Depth),
      .BASE_ADDR   (32'h0),
      .WAIT_CYCLES (W)
    ) u_dut (
      .clk_i        (clk),
      .n_rst_i      (rst_n),
      .pc_i         (pc),
      .ce_i         (ce),
      .flush_i      (flush),
      .hold_i       (hold),
      .inst_o       (inst_w[g]),
      .inst_pc_o    (ipc_w[g]),
      .inst_valid_o (valid_w[g]),
      .fault_o      (fault_w[g]),
      .stall_req_o  (stall_w[g]),
      .load_we_i    (we),
      .load_addr_i  (waddr),
      .load_data_i  (wdata)
    );

    // Model: "busy" = a fetch in flight, "shown" = a response on the outputs.
    bit          armed = 0, busy = 0, shown = 0, fresh = 0;
    int          remaining = 0;
    logic [31:0] f_pc = 0, r_pc = 0, r_inst = 0;
    logic [1:0]  r_fault = 0;
    logic [31:0] mem_m [Depth];

    always @(posedge clk) begin
      bit          pub;
      logic [31:0] pub_pc;
      pub    = 0;
      pub_pc = 0;
      armed  = 1;
      if (!rst_n) begin
        busy = 0; shown = 0; fresh = 1;
        r_inst = Nop; r_pc = 0; r_fault = 0;
      end else if (flush) begin
        busy = 0; shown = 0;
      end else if (busy) begin
        remaining--;
        if (remaining == 0) begin
          busy = 0; pub = 1; pub_pc = f_pc;
        end
      end else if (!(shown && hold)) begin
        shown = 0;
        if (ce) begin
          if (W == 0) begin
            pub = 1; pub_pc = pc;
          end else begin
            busy = 1; remaining = W; f_pc = pc;
          end
        end
      end
      if (pub) begin
        shown   = 1;
        fresh   = 0;
        r_pc    = pub_pc;
        r_fault = exp_fault(pub_pc);
        r_inst  = (r_fault != 2'b00) ? Nop : mem_m[(pub_pc >> 2) % Depth];
      end
      if (we) mem_m[waddr] = wdata;
    end

    always @(negedge clk) begin
      if (armed) begin
        bit take, st;
        take = ce && !flush && !busy && (!shown || !hold);
        st   = !flush && (busy || (take && (W > 0)) || (shown && hold && ce));
        check($sformatf("w%0d valid", W), 32'(valid_w[g]), 32'(shown));
        check($sformatf("w%0d stall", W), 32'(stall_w[g]), 32'(st));
        if (shown || fresh) begin
          check($sformatf("w%0d inst", W), inst_w[g], r_inst);
          check($sformatf("w%0d inst_pc", W), ipc_w[g], r_pc);
          check($sformatf("w%0d fault", W), 32'(fault_w[g]), 32'(r_fault));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    tick(2);
    check("rst inst", inst_w[0], Nop);
    check("rst pc", ipc_w[0], 32'd0);
    check("rst valid", 32'(valid_w[0]), 32'd0);
    check("rst fault", 32'(fault_w[1]), 32'd0);
    rst_n = 1'b1;

    // Preload every word, then the test pattern in words 0..3.
    for (int i = 0; i < 64; i++) begin
      we = 1'b1; waddr = AddrW'(i); wdata = 32'hA000_0000 + 32'(i);
      tick();
    end
    for (int i = 0; i < 4; i++) begin
      waddr = AddrW'(i); wdata = 32'h11 * 32'(i + 1);
      tick();
    end
    we = 1'b0;
    tick();

    // Back-to-back fetches, zero wait states.
    ce = 1'b1;
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      tick();
      check("b2b inst", inst_w[0], 32'h11 * 32'(i + 1));
      check("b2b pc", ipc_w[0], 32'(i * 4));
    end
    ce = 1'b0;
    tick(6);

    // Three wait states.
    pc = 32'h8; ce = 1'b1;
    #1 check("w3 stall accept", 32'(stall_w[1]), 32'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("w3 stall wait", 32'(stall_w[1]), 32'd1);
      check("w3 no valid", 32'(valid_w[1]), 32'd0);
    end
    tick();
    check("w3 valid", 32'(valid_w[1]), 32'd1);
    check("w3 inst", inst_w[1], 32'h33);
    check("w3 pc", ipc_w[1], 32'h8);
    ce = 1'b0;
    tick(6);

    // Hold freezes the response while pc moves on.
    pc = 32'h4; ce = 1'b1;
    tick();
    hold = 1'b1; pc = 32'h8;
    #1 check("hold stall", 32'(stall_w[0]), 32'd1);
    tick(2);
    check("hold inst", inst_w[0], 32'h22);
    check("hold pc", ipc_w[0], 32'h4);
    hold = 1'b0;
    tick();
    check("post-hold inst", inst_w[0], 32'h33);
    check("post-hold pc", ipc_w[0], 32'h8);
    ce = 1'b0;
    tick(6);

    // Flush in the second wait cycle, then a clean fetch.
    pc = 32'hC; ce = 1'b1;
    tick(2);
    flush = 1'b1;
    #1 check("flush stall", 32'(stall_w[1]), 32'd0);
    tick();
    flush = 1'b0; ce = 1'b0;
    tick(4);
    pc = 32'h0; ce = 1'b1;
    tick();
    ce = 1'b0;
    tick(3);
    check("after flush valid", 32'(valid_w[1]), 32'd1);
    check("after flush inst", inst_w[1], 32'h11);
    tick(4);

    // Faults and the last in-range word.
    ce = 1'b1;
    pc = 32'h6;         tick(); check("misalign", 32'(fault_w[0]), 32'd1);
    check("misalign nop", inst_w[0], Nop);
    pc = 32'(Depth * 4); tick(); check("range", 32'(fault_w[0]), 32'd2);
    check("range nop", inst_w[0], Nop);
    pc = 32'h3;         tick(); check("misalign low", 32'(fault_w[0]), 32'd1);
    pc = 32'hFFFF_FFFC; tick(); check("wrap range", 32'(fault_w[0]), 32'd2);
    pc = 32'(Depth * 4 - 4); tick(); check("top ok", 32'(fault_w[0]), 32'd0);
    check("top inst", inst_w[0], 32'hA000_003F);
    ce = 1'b0;
    tick(6);

    // Load collision on word 5: old data now, new data on refetch.
    pc = 32'd20; ce = 1'b1; we = 1'b1; waddr = AddrW'(5); wdata = 32'hDEAD_BEEF;
    tick();
    check("collide old", inst_w[0], 32'hA000_0005);
    we = 1'b0;
    tick();
    check("collide new", inst_w[0], 32'hDEAD_BEEF);
    ce = 1'b0;
    tick(6);

    // Reset in the middle of a wait.
    pc = 32'h8; ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check("mid rst valid", 32'(valid_w[1]), 32'd0);
    check("mid rst inst", inst_w[1], Nop);
    check("mid rst pc", ipc_w[1], 32'd0);
    check("mid rst stall", 32'(stall_w[1]), 32'd0);
    rst_n = 1'b1;
    tick(5);
    check("post rst valid", 32'(valid_w[1]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
